// File: rtl/spi_rom_responder_pkg.sv
// Shared definitions for the SPI ROM responder: opcodes, bit-counter
// reload values and the FSM state encoding.
package spi_rom_responder_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDSR = 8'h05;

    // Bit counter is a down-counter; reload value = bits in the field - 1,
    // terminal count is zero.
    localparam logic [4:0] CNT_BYTE = 5'd7;
    localparam logic [4:0] CNT_ADDR = 5'd23;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        STAT,
        SINK
    } state_t;

endpackage

// File: rtl/spi_rom_responder_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser for one asynchronous input plus a
// registered rise/fall detector on the synchronised level.
//   i_clk    : sampling clock
//   i_rst_n  : synchronous active-low reset
//   i_async  : asynchronous input
//   o_sync   : synchronised level
//   o_rise   : one-cycle pulse on a synchronised 0->1
//   o_fall   : one-cycle pulse on a synchronised 1->0
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic       r_rise;
    logic       r_fall;
    logic [1:0] r_fill;

    // r_fill suppresses edges until both r_sync and r_prev hold real samples,
    // so a level that differs from RST_VAL when reset releases (e.g. CS held
    // low through reset) is not mistaken for a fresh edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_fill <= 2'd3;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            if (r_fill != 2'd0) begin
                r_fill <= r_fill - 2'd1;
            end
            r_rise <= (r_fill == 2'd0) &  r_sync & ~r_prev;
            r_fall <= (r_fill == 2'd0) & ~r_sync &  r_prev;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/spi_rom_responder.sv
// SPI (mode 0) slave that serves a byte-wide ROM: READ (03 + 24-bit address,
// then streaming bytes with auto-increment) and RDSR (05, repeating status).
//   fclk         : system clock, all state on rising edge
//   rst_n        : synchronous active-low reset
//   spi_cs_n     : async chip select (active low)
//   spi_sck      : async SPI clock
//   spi_mosi     : async serial data in, MSB first
//   spi_miso     : serial data out, MSB first (1 when not driven)
//   spi_miso_oe  : high while spi_miso is driven
//   rom_addr     : ROM byte address
//   rom_data     : ROM byte, valid 1 fclk after rom_addr
//   busy         : inverted synchronised CS
//   cmd_err      : one-fclk pulse on an unsupported opcode
//
// state | meaning
// IDLE  | waiting for a CS falling edge
// CMD   | shifting in the 8-bit opcode
// ADDR  | shifting in the 24-bit address
// DATA  | streaming ROM bytes out, address increments per byte
// STAT  | streaming STATUS_VAL out repeatedly
// SINK  | unsupported opcode, ignore bus until CS rises
module spi_rom_responder
    import spi_rom_responder_pkg::*;
#(
    parameter int         ADDR_W     = 19,
    parameter logic [7:0] STATUS_VAL = 8'h00
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              busy,
    output logic              cmd_err
);

    // Only as many address bits as the ROM uses are kept; higher bits shift
    // out the top and are dropped.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_cmd_err;

    logic [4:0]        r_bit_cnt;
    logic [SH_W-1:0]   r_sh_in;
    logic [7:0]        r_sh_out;
    logic              r_miso;
    logic              r_oe;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_cmd_err;

    logic              w_cs_sync;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_sck_lvl_unused;
    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_mosi;
    logic              w_mosi_rise_unused;
    logic              w_mosi_fall_unused;

    logic              w_abort;
    logic [SH_W:0]     w_shift_in;
    logic [7:0]        w_opcode;
    logic [7:0]        w_load_byte;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk   (fclk),
        .i_rst_n (rst_n),
        .i_async (spi_cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .i_clk   (fclk),
        .i_rst_n (rst_n),
        .i_async (spi_sck),
        .o_sync  (w_sck_lvl_unused),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk   (fclk),
        .i_rst_n (rst_n),
        .i_async (spi_mosi),
        .o_sync  (w_mosi),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    // A deselected bus overrides everything, including SCK edges seen in
    // the same cycle.
    assign w_abort     = w_cs_sync | w_cs_rise;
    assign w_shift_in  = {r_sh_in, w_mosi};
    assign w_opcode    = w_shift_in[7:0];
    assign w_load_byte = (r_state == DATA) ? rom_data : STATUS_VAL;

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_err    = 1'b0;
        if (w_abort) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        w_next_state = CMD;
                    end
                end
                CMD: begin
                    if (w_sck_rise && (r_bit_cnt == 5'd0)) begin
                        if (w_opcode == OP_READ) begin
                            w_next_state = ADDR;
                        end else if (w_opcode == OP_RDSR) begin
                            w_next_state = STAT;
                        end else begin
                            w_next_state = SINK;
                            w_cmd_err    = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (w_sck_rise && (r_bit_cnt == 5'd0)) begin
                        w_next_state = DATA;
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            r_bit_cnt  <= 5'd0;
            r_sh_in    <= '0;
            r_sh_out   <= 8'hFF;
            r_miso     <= 1'b1;
            r_oe       <= 1'b0;
            r_rom_addr <= '0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_err;
            if (w_abort) begin
                r_miso    <= 1'b1;
                r_oe      <= 1'b0;
                r_bit_cnt <= 5'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso <= 1'b1;
                        r_oe   <= 1'b0;
                        if (w_cs_fall) begin
                            r_bit_cnt <= CNT_BYTE;
                        end
                    end
                    CMD: begin
                        if (w_sck_rise) begin
                            r_sh_in <= w_shift_in[SH_W-1:0];
                            if (r_bit_cnt == 5'd0) begin
                                r_bit_cnt <= (w_opcode == OP_READ) ? CNT_ADDR : CNT_BYTE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_sck_rise) begin
                            r_sh_in <= w_shift_in[SH_W-1:0];
                            if (r_bit_cnt == 5'd0) begin
                                r_rom_addr <= w_shift_in[ADDR_W-1:0];
                                r_bit_cnt  <= CNT_BYTE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 5'd1;
                            end
                        end
                    end
                    DATA, STAT: begin
                        // Counter at its reload value on a fall means the
                        // previous byte is finished: present bit 7 of the next.
                        if (w_sck_fall) begin
                            r_oe <= 1'b1;
                            if (r_bit_cnt == CNT_BYTE) begin
                                r_miso   <= w_load_byte[7];
                                r_sh_out <= {w_load_byte[6:0], 1'b1};
                            end else begin
                                r_miso   <= r_sh_out[7];
                                r_sh_out <= {r_sh_out[6:0], 1'b1};
                            end
                        end else if (w_sck_rise) begin
                            if (r_bit_cnt == 5'd0) begin
                                r_bit_cnt <= CNT_BYTE;
                                if (r_state == DATA) begin
                                    r_rom_addr <= r_rom_addr + ADDR_W'(1);
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 5'd1;
                            end
                        end
                    end
                    default: begin
                        r_bit_cnt <= r_bit_cnt;
                    end
                endcase
            end
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_oe;
    assign rom_addr    = r_rom_addr;
    assign busy        = ~w_cs_sync;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_spi_rom_responder.sv
// Testbench for spi_rom_responder: bit-banged SPI master, ROM model with
// ROM[i] = i[7:0], scoreboard queue of expected MISO bytes.
`timescale 1ns/1ps
module tb_spi_rom_responder;

    localparam int ADDR_W = 19;
    localparam int HALF   = 60;

    logic              fclk     = 1'b0;
    logic              rst_n    = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              spi_sck  = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data = 8'h00;
    logic              busy;
    logic              cmd_err;

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] sb_q[$];
    int         err_pulses = 0;
    logic       oe_seen    = 1'b0;
    logic       mon_en     = 1'b0;
    logic [7:0] rx;
    logic       rx_bit;

    always #5 fclk = ~fclk;

    always @(posedge fclk) rom_data <= rom_addr[7:0];

    always @(negedge fclk) begin
        if (mon_en) begin
            if (cmd_err) err_pulses = err_pulses + 1;
            if (spi_miso_oe) oe_seen = 1'b1;
        end
    end

    spi_rom_responder #(.ADDR_W(ADDR_W), .STATUS_VAL(8'h00)) dut (
        .fclk        (fclk),
        .rst_n       (rst_n),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .busy        (busy),
        .cmd_err     (cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic tx, output logic rxb);
        spi_mosi = tx;
        #HALF spi_sck = 1'b1;
        rxb = spi_miso;
        #HALF spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rxv);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rxv[i] = b;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF spi_cs_n = 1'b1;
        #(HALF * 2);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] got);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    task automatic read_burst(input logic [23:0] addr, input int n);
        logic [7:0]  d;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            a = (32'(addr) + 32'(k)) % (32'd1 << ADDR_W);
            sb_q.push_back(a[7:0]);
        end
        cs_low();
        spi_byte(8'h03, d);
        spi_byte(addr[23:16], d);
        spi_byte(addr[15:8], d);
        spi_byte(addr[7:0], d);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'h00, d);
            pop_chk("rd_byte", d);
        end
        cs_high();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge fclk);
        chk("rst_miso",    32'(spi_miso),    32'd1);
        chk("rst_oe",      32'(spi_miso_oe), 32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_cmd_err", 32'(cmd_err),     32'd0);
        chk("rst_addr",    32'(rom_addr),    32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge fclk);

        read_burst(24'h000100, 4);
        chk("read_addr_end", 32'(rom_addr), 32'h104);

        read_burst(24'h07FFFE, 4);
        chk("wrap_addr_end", 32'(rom_addr), 32'h2);

        read_burst(24'hF80005, 1);
        chk("hi_bits_addr_end", 32'(rom_addr), 32'h6);

        // RDSR: output enable must appear exactly with the first post-opcode fall
        sb_q.push_back(8'h00);
        sb_q.push_back(8'h00);
        cs_low();
        spi_byte(8'h05, rx);
        #30 chk("rdsr_oe_before", 32'(spi_miso_oe), 32'd0);
        #10 chk("rdsr_oe_after",  32'(spi_miso_oe), 32'd1);
        spi_byte(8'h00, rx);
        pop_chk("rdsr_byte", rx);
        spi_byte(8'h00, rx);
        pop_chk("rdsr_byte", rx);
        cs_high();
        chk("rdsr_oe_idle", 32'(spi_miso_oe), 32'd0);

        // Unsupported opcode then 16 more clocks
        err_pulses = 0;
        oe_seen    = 1'b0;
        mon_en     = 1'b1;
        sb_q.push_back(8'hFF);
        sb_q.push_back(8'hFF);
        cs_low();
        spi_byte(8'h9F, rx);
        spi_byte(8'hA5, rx);
        pop_chk("sink_byte", rx);
        spi_byte(8'h03, rx);
        pop_chk("sink_byte", rx);
        cs_high();
        mon_en = 1'b0;
        chk("cmd_err_pulses", 32'(err_pulses), 32'd1);
        chk("sink_oe_seen",   32'(oe_seen),    32'd0);

        // Abort a READ after 13 bits
        cs_low();
        spi_byte(8'h03, rx);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, rx_bit);
        cs_high();
        chk("abort_addr_hold", 32'(rom_addr), 32'h6);
        read_burst(24'h000010, 1);

        // Reset pulse during DATA
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h20, rx);
        sb_q.push_back(8'h20);
        spi_byte(8'h00, rx);
        pop_chk("pre_rst_byte", rx);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, rx_bit);
        @(negedge fclk);
        rst_n = 1'b0;
        @(negedge fclk);
        chk("mid_rst_miso",    32'(spi_miso),    32'd1);
        chk("mid_rst_oe",      32'(spi_miso_oe), 32'd0);
        chk("mid_rst_busy",    32'(busy),        32'd0);
        chk("mid_rst_cmd_err", 32'(cmd_err),     32'd0);
        chk("mid_rst_addr",    32'(rom_addr),    32'd0);
        rst_n = 1'b1;
        cs_high();
        repeat (10) @(negedge fclk);
        read_burst(24'h000040, 2);
        chk("post_rst_addr_end", 32'(rom_addr), 32'h42);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
